// File: rtl/prio_arb_ctrl.sv
// Four-requester arbiter with registered one-hot grant, hold limit and release gap.
// Define PRIO_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (bit 3 highest).
module prio_arb_ctrl #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [3:0]    gnt_reg, gnt_next;
    logic [1:0]    gnt_id_reg, gnt_id_next;
    logic          gnt_valid_reg, gnt_valid_next;
    logic          timeout_reg, timeout_next;
    logic [CW-1:0] hold_cnt_reg, hold_cnt_next;

    logic [1:0]    base_id;
    logic [3:0]    rot_req;
    logic [1:0]    win_ofs;
    logic [1:0]    win_id;
    logic [3:0]    win_onehot;
    logic          owner_done;
    logic          owner_req;
    logic          at_limit;

`ifdef PRIO_ARB_RR_EN
    logic [1:0]    last_id_reg, last_id_next;
    assign base_id = last_id_reg;
`else
    assign base_id = 2'd0;
`endif

    // Rotate requests so the highest set bit of rot_req is always the preferred winner;
    // with base_id = last owner this yields search order last-1, last-2, last-3, last.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi]    = req[2'(base_id + 2'(gi))];
            assign win_onehot[gi] = (win_id == 2'(gi));
        end
    endgenerate

    always_comb begin
        win_ofs = 2'd0;
        for (int j = 0; j < 4; j++) begin
            if (rot_req[j]) begin
                win_ofs = 2'(j);
            end
        end
    end

    assign win_id     = base_id + win_ofs;
    assign owner_done = done[gnt_id_reg];
    assign owner_req  = req[gnt_id_reg];
    assign at_limit   = (hold_cnt_reg == CW'(MAX_HOLD));

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        gnt_id_next    = gnt_id_reg;
        gnt_valid_next = gnt_valid_reg;
        timeout_next   = 1'b0;
        hold_cnt_next  = hold_cnt_reg;
`ifdef PRIO_ARB_RR_EN
        last_id_next   = last_id_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    state_next     = ST_GRANT;
                    gnt_next       = win_onehot;
                    gnt_id_next    = win_id;
                    gnt_valid_next = 1'b1;
                    hold_cnt_next  = CW'(1);
`ifdef PRIO_ARB_RR_EN
                    last_id_next   = win_id;
`endif
                end
            end
            ST_GRANT: begin
                if (owner_done || !owner_req || at_limit) begin
                    state_next     = ST_GAP;
                    gnt_next       = 4'b0000;
                    gnt_id_next    = 2'd0;
                    gnt_valid_next = 1'b0;
                    hold_cnt_next  = '0;
                    // A voluntary release on the same edge masks the forced one.
                    timeout_next   = at_limit && !owner_done && owner_req;
                end else begin
                    hold_cnt_next  = hold_cnt_reg + CW'(1);
                end
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next     = ST_IDLE;
                gnt_next       = 4'b0000;
                gnt_id_next    = 2'd0;
                gnt_valid_next = 1'b0;
                hold_cnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            gnt_reg       <= 4'b0000;
            gnt_id_reg    <= 2'd0;
            gnt_valid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            hold_cnt_reg  <= '0;
`ifdef PRIO_ARB_RR_EN
            last_id_reg   <= 2'd0;
`endif
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            gnt_id_reg    <= gnt_id_next;
            gnt_valid_reg <= gnt_valid_next;
            timeout_reg   <= timeout_next;
            hold_cnt_reg  <= hold_cnt_next;
`ifdef PRIO_ARB_RR_EN
            last_id_reg   <= last_id_next;
`endif
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_id    = gnt_id_reg;
    assign gnt_valid = gnt_valid_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_prio_arb_ctrl.sv
// Scoreboard bench for prio_arb_ctrl: directed scenarios followed by random traffic.
module tb_prio_arb_ctrl;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] done = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    prio_arb_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       v;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cycle_no = 0;

    // Reference model: who owns the resource, for how long, and whether we are in the gap.
    int m_owner = -1;
    int m_held  = 0;
    bit m_gap   = 1'b0;
    int m_last  = 0;
    bit m_to    = 1'b0;

    function automatic int pick_winner(input logic [3:0] r, input int last);
        int w;
        w = -1;
`ifdef PRIO_ARB_RR_EN
        for (int k = 1; k <= 4; k++) begin
            int cand;
            cand = (last - k + 8) % 4;
            if (w < 0 && r[cand]) w = cand;
        end
`else
        for (int i = 3; i >= 0; i--) begin
            if (w < 0 && r[i]) w = i;
        end
`endif
        return w;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic [3:0] d, input logic rs);
        exp_t e;
        if (rs) begin
            m_owner = -1; m_held = 0; m_gap = 1'b0; m_last = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner >= 0) begin
                bit by_done, by_drop, by_limit;
                by_done  = d[m_owner];
                by_drop  = !r[m_owner];
                by_limit = (m_held == MAX_HOLD);
                if (by_done || by_drop || by_limit) begin
                    m_to    = by_limit && !by_done && !by_drop;
                    m_owner = -1;
                    m_held  = 0;
                    m_gap   = 1'b1;
                end else begin
                    m_held++;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (r != 4'b0000) begin
                m_owner = pick_winner(r, m_last);
                m_last  = m_owner;
                m_held  = 1;
            end
        end
        e.g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e.v  = (m_owner >= 0);
        e.to = m_to;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, let the edge sample them, then record the expectation.
    task automatic cyc(input logic [3:0] r, input logic [3:0] d, input logic rs);
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        #1;
        cycle_no++;
        model_step(r, d, rs);
    endtask

    // Monitor: DUT outputs are valid every cycle; compare on the falling edge.
    initial begin : monitor
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                if (gnt !== e.g || gnt_id !== e.id || gnt_valid !== e.v || timeout !== e.to) begin
                    bad++;
                    $display("FAIL outputs cycle %0d: got gnt=%b id=%0d valid=%b timeout=%b, want gnt=%b id=%0d valid=%b timeout=%b",
                             cycle_no, gnt, gnt_id, gnt_valid, timeout, e.g, e.id, e.v, e.to);
                end
                if (gnt_valid && !prev_v)
                    $display("grant cycle %0d owner=%0d gnt=%b", cycle_no, gnt_id, gnt);
                if (timeout)
                    $display("timeout cycle %0d", cycle_no);
                prev_v = gnt_valid;
            end
        end
    end

    initial begin : stimulus
        logic [3:0] r;
        logic [3:0] d;
        logic       rs;

        cyc(4'b0000, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        repeat (5) cyc(4'b0000, 4'b0000, 1'b0);

        // Two requesters, owner 3 releases with done on its 3rd grant cycle.
        cyc(4'b1100, 4'b0000, 1'b0);
        repeat (2) cyc(4'b1100, 4'b0000, 1'b0);
        cyc(4'b1100, 4'b1000, 1'b0);
        repeat (5) cyc(4'b1100, 4'b0000, 1'b0);
        repeat (2) cyc(4'b0000, 4'b0000, 1'b0);

        // Owner never releases: forced revoke with timeout.
        repeat (8) cyc(4'b0001, 4'b0000, 1'b0);
        repeat (2) cyc(4'b0000, 4'b0000, 1'b0);

        // done arrives on the same edge as the hold limit: no timeout.
        repeat (4) cyc(4'b0001, 4'b0000, 1'b0);
        cyc(4'b0001, 4'b0001, 1'b0);
        repeat (3) cyc(4'b0000, 4'b0000, 1'b0);

        // Non-owner done is ignored.
        cyc(4'b0100, 4'b0000, 1'b0);
        repeat (2) cyc(4'b0100, 4'b0001, 1'b0);
        cyc(4'b0100, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        repeat (2) cyc(4'b0000, 4'b0000, 1'b0);

        // Reset in the middle of a grant, then all four requesting for several grants.
        repeat (2) cyc(4'b1111, 4'b0000, 1'b0);
        cyc(4'b1111, 4'b0000, 1'b1);
        repeat (20) cyc(4'b1111, 4'b0000, 1'b0);

        // Random traffic with persistent requests, sparse done pulses and rare resets.
        r = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            case ($urandom_range(0, 9))
                0, 1:    d = 4'(1 << $urandom_range(0, 3));
                2:       d = 4'($urandom);
                default: d = 4'b0000;
            endcase
            rs = ($urandom_range(0, 299) == 0);
            cyc(r, d, rs);
        end

        cyc(4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
